// File: rtl/mc16_pkg.sv
// Shared constants and FSM state encoding for the microcore16 program loader.
package mc16_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 8;
  localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_LEN, ST_HI, ST_LO, ST_CHK, ST_DONE, ST_ERR
  } state_t;
endpackage

// File: rtl/mc16_prog_loader.sv
// Serial program-image loader: parses A5/len/data/xor frames from a byte
// stream, writes 16-bit words into program memory and releases the core.
module mc16_prog_loader
  import mc16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_en,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_run,
  output logic              err
);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx, len_q, len_nx, addr_q, addr_nx;
  logic [BYTE_W-1:0] hi_q, hi_nx, csum_q, csum_nx;
  logic [WORD_W-1:0] wdata_q, wdata_nx;
  logic              we_q, we_nx, run_q, run_nx;
  logic              in_frame, accept;

  assign in_frame   = (state == ST_HDR) || (state == ST_LEN) || (state == ST_HI) ||
                      (state == ST_LO)  || (state == ST_CHK);
  // Bytes are refused during the write cycle so the counter settles first.
  assign byte_ready = ena && in_frame && !we_q;
  assign accept     = byte_valid && byte_ready;
  assign mem_we     = we_q && ena && load_en;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_run   = run_q;
  assign err        = (state == ST_ERR);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    len_nx   = len_q;
    hi_nx    = hi_q;
    csum_nx  = csum_q;
    we_nx    = we_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    run_nx   = run_q;
    if (ena) begin
      we_nx = 1'b0;
      if (we_q && cnt != {ADDR_W{1'b1}}) cnt_nx = cnt + 1'b1;
      unique case (state)
        ST_IDLE: if (load_en) state_nx = ST_HDR;
        ST_HDR:  if (accept && byte_data == HDR_BYTE) state_nx = ST_LEN;
        ST_LEN: if (accept) begin
          if (byte_data == '0) state_nx = ST_ERR;
          else begin
            len_nx   = byte_data;
            cnt_nx   = '0;
            csum_nx  = '0;
            state_nx = ST_HI;
          end
        end
        ST_HI: if (accept) begin
          hi_nx    = byte_data;
          csum_nx  = csum_q ^ byte_data;
          state_nx = ST_LO;
        end
        ST_LO: if (accept) begin
          csum_nx  = csum_q ^ byte_data;
          we_nx    = 1'b1;
          addr_nx  = cnt;
          wdata_nx = {hi_q, byte_data};
          state_nx = (cnt == len_q - 1'b1) ? ST_CHK : ST_HI;
        end
        ST_CHK: if (accept) state_nx = (byte_data == csum_q) ? ST_DONE : ST_ERR;
        ST_DONE, ST_ERR: if (!load_en) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
      // Host abort wins over everything, including a queued write.
      if (!load_en && state != ST_IDLE) begin
        state_nx = ST_IDLE;
        we_nx    = 1'b0;
      end
      run_nx = (state_nx == ST_IDLE) || (state_nx == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      len_q   <= len_nx;
      hi_q    <= hi_nx;
      csum_q  <= csum_nx;
      we_q    <= we_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      run_q   <= run_nx;
    end
  end
endmodule

// File: tb/tb_mc16_prog_loader.sv
// Directed plus randomized frame checks against a sequential frame-parser model.
module tb_mc16_prog_loader;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b1, load_en = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, core_run, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  int n_cmp = 0, n_bad = 0;
  logic [23:0] got[$];
  logic        prev_we = 1'b0;

  mc16_prog_loader dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load_en(load_en),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_run(core_run), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture every write; a strobe must never stay high two cycles in a row.
  always @(negedge clk) begin
    if (mem_we) begin
      got.push_back({mem_addr, mem_wdata});
      if (prev_we) chk("we_one_cycle", 32'd1, 32'd0);
    end
    prev_we <= mem_we;
  end

  // Reference: walk the byte stream as the frame format describes it.
  // status 0 = incomplete, 1 = done, 2 = error
  task automatic model(input bq_t bytes, output logic [23:0] wr[$], output int status);
    int phase = 0, n = 0, i = 0;
    logic [7:0] cs = 0, hi = 0;
    wr.delete();
    status = 0;
    foreach (bytes[k]) begin
      if (status != 0) break;
      case (phase)
        0: if (bytes[k] == 8'hA5) phase = 1;
        1: if (bytes[k] == 8'h00) status = 2;
           else begin n = bytes[k]; i = 0; cs = 0; phase = 2; end
        2: begin hi = bytes[k]; cs ^= bytes[k]; phase = 3; end
        3: begin
          cs ^= bytes[k];
          wr.push_back({i[7:0], hi, bytes[k]});
          i++;
          phase = (i == n) ? 4 : 2;
        end
        default: status = (bytes[k] == cs) ? 1 : 2;
      endcase
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic finish_check(input string tag, input bq_t bytes);
    logic [23:0] exp[$];
    int st;
    repeat (3) @(negedge clk);
    model(bytes, exp, st);
    chk({tag, "_nwr"}, got.size(), exp.size());
    foreach (exp[k]) if (k < got.size()) chk({tag, "_wr"}, got[k], exp[k]);
    chk({tag, "_err"}, err, st == 2);
    chk({tag, "_run"}, core_run, st == 1);
    load_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_err"}, err, 0);
    chk({tag, "_idle_run"}, core_run, 1);
  endtask

  task automatic run_frame(input string tag, input bq_t bytes);
    got.delete();
    @(negedge clk);
    load_en = 1'b1;
    foreach (bytes[k]) send_byte(bytes[k]);
    finish_check(tag, bytes);
  endtask

  initial begin
    bq_t f;
    logic [7:0] cs, w;
    #3;
    chk("rst_we", mem_we, 0);
    chk("rst_err", err, 0);
    chk("rst_run", core_run, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("run_after_rst", core_run, 1);

    run_frame("good", '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD});
    run_frame("badcs", '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00});
    run_frame("junk", '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h51});
    run_frame("n0", '{8'hA5, 8'h00});

    // Abort after the high byte of the first word.
    got.delete();
    @(negedge clk);
    load_en = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    @(negedge clk);
    load_en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_run", core_run, 1);
    chk("abort_ready", byte_ready, 0);
    repeat (2) @(negedge clk);
    chk("abort_nwr", got.size(), 0);

    // Tile stall mid-frame with a byte on offer.
    got.delete();
    @(negedge clk);
    load_en = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    @(negedge clk);
    ena = 1'b0; byte_valid = 1'b1; byte_data = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ready", byte_ready, 0);
      chk("stall_we", mem_we, 0);
    end
    ena = 1'b1; byte_valid = 1'b0;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
    finish_check("stall", '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44});

    // Reset asserted while waiting for a low byte.
    got.delete();
    @(negedge clk);
    load_en = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", byte_ready, 0);
    chk("midrst_run", core_run, 0);
    chk("midrst_err", err, 0);
    chk("midrst_we", mem_we, 0);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("midrst_run_rel", core_run, 1);
    repeat (3) @(negedge clk);
    chk("midrst_nwr", got.size(), 0);

    for (int it = 0; it < 8; it++) begin
      f.delete();
      for (int j = 0; j < $urandom_range(0, 2); j++) begin
        w = 8'($urandom);
        f.push_back(w == 8'hA5 ? 8'h00 : w);
      end
      f.push_back(8'hA5);
      w = 8'($urandom_range(1, 6));
      f.push_back(w);
      cs = 8'h00;
      for (int j = 0; j < 2 * int'(w); j++) begin
        f.push_back(8'($urandom));
        cs ^= f[f.size() - 1];
      end
      if ($urandom_range(0, 2) == 0) cs ^= 8'($urandom_range(1, 255));
      f.push_back(cs);
      run_frame("rand", f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc16_prog_loader.md
MC16_PROG_LOADER -- requirements
Module: mc16_prog_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk in, rst_n in.
REQ-002 SHALL expose: clk  input  1  rising-edge clock.
REQ-003 SHALL expose: rst_n  input  1  async active-low reset.
REQ-004 SHALL expose: ena  input  1  tile enable; low freezes all state.
REQ-005 SHALL expose: load_en  input  1  host request to hold core and accept a program image.
REQ-006 SHALL expose: byte_valid  input  1  byte_data holds a valid byte.
REQ-007 SHALL expose: byte_data  input  8  serial image byte.
REQ-008 SHALL expose: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL expose: mem_we  output  1  program-memory write strobe.
REQ-010 SHALL expose: mem_addr  output  8  word address.
REQ-011 SHALL expose: mem_wdata  output  16  instruction word.
REQ-012 SHALL expose: core_run  output  1  releases microcore16 from hold.
REQ-013 SHALL expose: err  output  1  load failure flag.

Function
REQ-014 Byte accept SHALL occur only on a cycle where byte_valid && byte_ready && ena.
REQ-015 Frame format SHALL be: 0xA5 header, length N (words, 1..255), 2N data bytes (high byte first per word), checksum byte = XOR of all 2N data bytes.
REQ-016 FSM states SHALL be IDLE, HDR, LEN, HI, LO, CHK, DONE, ERR.
REQ-017 IDLE: core_run=1, byte_ready=0; load_en=1 -> HDR next cycle.
REQ-018 HDR: accepted 0xA5 -> LEN; any other accepted byte is discarded and the FSM stays in HDR (resync).
REQ-019 LEN: accepted N=0 -> ERR; else N is latched, address counter is cleared to 0, checksum is cleared, and the FSM goes to HI.
REQ-020 HI: accepted byte is latched as the high byte -> LO.
REQ-021 LO: accepted byte completes the word; in the following cycle mem_we=1 for exactly one cycle, with mem_addr = current count and mem_wdata = {hi,lo}.
REQ-022 After each write the counter SHALL increment; after the Nth word -> CHK, else -> HI.
REQ-023 CHK: accepted byte equal to the running XOR -> DONE; mismatch -> ERR.
REQ-024 DONE: core_run=1 and err=0; the FSM stays in DONE until load_en=0, then -> IDLE.
REQ-025 ERR: err=1, core_run=0, byte_ready=0; the FSM stays in ERR until load_en=0, then -> IDLE.
REQ-026 byte_ready SHALL be 1 only in HDR, LEN, HI, LO, CHK, and only when ena=1 and no write is pending in the current cycle.
REQ-027 core_run SHALL be 0 in HDR through CHK and in ERR.
REQ-028 load_en falling in any state other than IDLE SHALL abort -> IDLE next cycle; a pending write is suppressed.
REQ-029 ena=0 SHALL hold all registers, force byte_ready=0 and mem_we=0, and cause no state change.
REQ-030 The counter SHALL be 8 bits and never wrap: the maximum address is 254 (N=255).

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, counter 0, checksum 0, mem_we 0, mem_addr 0, mem_wdata 0, err 0, byte_ready 0.
REQ-032 core_run SHALL be 0 while rst_n is low and SHALL assert 1 cycle after reset release when load_en=0.
REQ-033 Reset mid-frame SHALL discard the partial frame; no further mem_we is issued.

Structure
REQ-034 Shared package mc16_pkg SHALL hold the FSM state enum, the header constant 0xA5 and the width constants (byte 8, word 16, address 8).
REQ-035 The block SHALL be a single module with no sub-module; the checksum is an inline XOR register.

Verification
REQ-036 Good frame A5,02,12,34,AB,CD,(12^34^AB^CD) -> writes addr0=0x1234 and addr1=0xABCD, each mem_we one cycle wide one cycle after the LO byte; then DONE with core_run=1.
REQ-037 Bad checksum: the same frame with a final byte of 0x00 -> both writes occur, then err=1, core_run=0; load_en low -> IDLE with err=0.
REQ-038 Junk before header 00,FF,A5,01,BE,EF,51 -> junk is ignored, a single write of addr0=0xBEEF occurs, then DONE.
REQ-039 N=0 (A5,00) -> ERR with no mem_we pulses.
REQ-040 load_en dropped after the HI byte of word 1 -> no write; IDLE next cycle; core_run=1.
REQ-041 ena low for 5 cycles mid-frame with byte_valid held high -> no accepts and no state change; the frame then completes correctly.
REQ-042 rst_n asserted in LO -> outputs take their reset values immediately, without waiting for a clock edge.
